// File: rtl/dmem_block_mover.sv
// dmem_block_mover: second master on the data-memory port that copies (or fills) word blocks.
// Fill mode is compiled in only when DMEM_FILL_EN is defined.
module dmem_block_mover #(
  parameter int ADDR_W    = 32,
  parameter int DATA_W    = 32,
  parameter int LEN_W     = 16,
  parameter int MEM_WORDS = 10001
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic [ADDR_W-1:0] src_addr,
  input  logic [ADDR_W-1:0] dst_addr,
  input  logic [LEN_W-1:0]  len,
  input  logic              fill,
  input  logic [DATA_W-1:0] fill_value,
  output logic              busy,
  output logic              done,
  output logic              error,
  output logic [ADDR_W-1:0] mem_A,
  output logic [DATA_W-1:0] mem_WD,
  output logic              mem_WE,
  input  logic [DATA_W-1:0] mem_RD
);

  // Command protocol: start is taken only in IDLE; busy covers READ/WRITE;
  // done (with error if rejected) pulses for exactly one cycle in FINISH.
  typedef enum logic [1:0] {IDLE, READ, WRITE, FINISH} state_t;

  localparam logic [ADDR_W:0] LIMIT = (ADDR_W+1)'(MEM_WORDS);

  state_t            state;
  logic [ADDR_W-1:0] src_q;
  logic [ADDR_W-1:0] dst_q;
  logic [LEN_W-1:0]  len_q;
  logic [LEN_W-1:0]  idx;
  logic [LEN_W-1:0]  idx_nx;
  logic              fill_sel;
  logic              fill_q;
  logic [ADDR_W:0]   len_ext;
  logic [ADDR_W:0]   src_end;
  logic [ADDR_W:0]   dst_end;
  logic              reject;
  logic              last;

`ifdef DMEM_FILL_EN
  assign fill_sel = fill;
`else
  logic unused_fill;
  assign unused_fill = ^{fill, fill_value};
  assign fill_sel    = 1'b0;
  assign fill_q      = 1'b0;
`endif

  // Range check one bit wider than the address so src+len cannot wrap.
  assign len_ext = (ADDR_W+1)'(len);
  assign src_end = {1'b0, src_addr} + len_ext;
  assign dst_end = {1'b0, dst_addr} + len_ext;
  assign reject  = (!fill_sel && (src_end > LIMIT)) || (dst_end > LIMIT);

  assign idx_nx = idx + LEN_W'(1);
  assign last   = (idx == len_q - LEN_W'(1));

  // mem_WD doubles as the data register that carries the read word into WRITE.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state  <= IDLE;
      src_q  <= '0;
      dst_q  <= '0;
      len_q  <= '0;
      idx    <= '0;
`ifdef DMEM_FILL_EN
      fill_q <= 1'b0;
`endif
      busy   <= 1'b0;
      done   <= 1'b0;
      error  <= 1'b0;
      mem_A  <= '0;
      mem_WD <= '0;
      mem_WE <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            src_q  <= src_addr;
            dst_q  <= dst_addr;
            len_q  <= len;
            idx    <= '0;
`ifdef DMEM_FILL_EN
            fill_q <= fill;
`endif
            if (reject || (len == '0)) begin
              state <= FINISH;
              done  <= 1'b1;
              error <= reject;
            end
`ifdef DMEM_FILL_EN
            else if (fill) begin
              state  <= WRITE;
              busy   <= 1'b1;
              mem_A  <= dst_addr;
              mem_WD <= fill_value;
              mem_WE <= 1'b1;
            end
`endif
            else begin
              state <= READ;
              busy  <= 1'b1;
              mem_A <= src_addr;
            end
          end
        end
        READ: begin
          state  <= WRITE;
          mem_WD <= mem_RD;
          mem_A  <= dst_q + ADDR_W'(idx);
          mem_WE <= 1'b1;
        end
        WRITE: begin
          if (last) begin
            state  <= FINISH;
            busy   <= 1'b0;
            done   <= 1'b1;
            mem_A  <= '0;
            mem_WD <= '0;
            mem_WE <= 1'b0;
          end else begin
            idx <= idx_nx;
            if (fill_q) begin
              mem_A <= dst_q + ADDR_W'(idx_nx);
            end else begin
              state  <= READ;
              mem_A  <= src_q + ADDR_W'(idx_nx);
              mem_WD <= '0;
              mem_WE <= 1'b0;
            end
          end
        end
        FINISH: begin
          state <= IDLE;
          done  <= 1'b0;
          error <= 1'b0;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_dmem_block_mover.sv
// Bench for dmem_block_mover: per-cycle output model built from the block-move rules,
// a behavioural data memory, and literal checks on timing and memory contents.
module tb_dmem_block_mover;

  localparam int ADDR_W    = 32;
  localparam int DATA_W    = 32;
  localparam int LEN_W     = 16;
  localparam int MEM_WORDS = 10001;
`ifdef DMEM_FILL_EN
  localparam bit FILL_BUILD = 1'b1;
`else
  localparam bit FILL_BUILD = 1'b0;
`endif

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic              start = 1'b0;
  logic [ADDR_W-1:0] src_addr = '0;
  logic [ADDR_W-1:0] dst_addr = '0;
  logic [LEN_W-1:0]  len = '0;
  logic              fill = 1'b0;
  logic [DATA_W-1:0] fill_value = '0;
  logic              busy;
  logic              done;
  logic              error;
  logic [ADDR_W-1:0] mem_A;
  logic [DATA_W-1:0] mem_WD;
  logic              mem_WE;
  logic [DATA_W-1:0] mem_RD;

  dmem_block_mover #(
    .ADDR_W(ADDR_W), .DATA_W(DATA_W), .LEN_W(LEN_W), .MEM_WORDS(MEM_WORDS)
  ) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .src_addr(src_addr), .dst_addr(dst_addr),
    .len(len), .fill(fill), .fill_value(fill_value), .busy(busy), .done(done),
    .error(error), .mem_A(mem_A), .mem_WD(mem_WD), .mem_WE(mem_WE), .mem_RD(mem_RD)
  );

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc++;

  // ---------------- data memory (DUT side) and model memory ----------------
  logic [DATA_W-1:0] mem       [MEM_WORDS];
  logic [DATA_W-1:0] model_mem [MEM_WORDS];

  assign mem_RD = (mem_A < ADDR_W'(MEM_WORDS)) ? mem[mem_A[13:0]] : '0;

  always @(posedge clk) begin
    if (mem_WE && (mem_A < ADDR_W'(MEM_WORDS))) mem[mem_A[13:0]] <= mem_WD;
  end

  // ---------------- scoreboard ----------------
  typedef struct {
    logic        busy;
    logic        done;
    logic        err;
    logic        we;
    logic [31:0] a;
    logic [31:0] wd;
    bit          chk_wd;
  } exp_t;

  exp_t exp_q[$];
  int   checks = 0;
  int   errors = 0;
  int   we_count = 0;
  int   last_done_cyc = -1;
  int   last_err_cyc = -1;
  int   start_cyc = 0;

  always @(negedge clk) begin
    exp_t e;
    if (rst_n && exp_q.size() > 0) begin
      e = exp_q.pop_front();
      checks++;
      if (busy !== e.busy || done !== e.done || error !== e.err || mem_WE !== e.we ||
          mem_A !== e.a || (e.chk_wd && mem_WD !== e.wd)) begin
        errors++;
        $display("FAIL trace cyc+%0d got busy=%b done=%b err=%b we=%b a=%0d wd=%h exp busy=%b done=%b err=%b we=%b a=%0d wd=%h",
                 cyc - start_cyc, busy, done, error, mem_WE, mem_A, mem_WD,
                 e.busy, e.done, e.err, e.we, e.a, e.wd);
      end
    end
    if (mem_WE) we_count++;
    if (done)   last_done_cyc = cyc;
    if (error)  last_err_cyc = cyc;
  end

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h", name, got, exp);
    end
  endtask

  task automatic push(input logic b, input logic d, input logic er, input logic w,
                      input logic [31:0] a, input logic [31:0] wd, input bit cw);
    exp_t e;
    e.busy = b; e.done = d; e.err = er; e.we = w; e.a = a; e.wd = wd; e.chk_wd = cw;
    exp_q.push_back(e);
  endtask

  // Expected output trace of one command, from cycle 0 to the idle cycle after done.
  task automatic model_cmd(input int s, input int d, input int n, input bit fl,
                           input logic [31:0] fv);
    bit          fm;
    bit          rej;
    logic [31:0] w;
    fm  = fl && FILL_BUILD;
    rej = (!fm && (s + n > MEM_WORDS)) || (d + n > MEM_WORDS);
    push(0, 0, 0, 0, 0, 0, 1);
    if (!rej && n > 0) begin
      for (int k = 0; k < n; k++) begin
        if (!fm) push(1, 0, 0, 0, 32'(s + k), 0, 0);
        w = fm ? fv : model_mem[s + k];
        push(1, 0, 0, 1, 32'(d + k), w, 1);
        model_mem[d + k] = w;
      end
    end
    push(0, 1, rej, 0, 0, 0, 1);
    push(0, 0, 0, 0, 0, 0, 1);
  endtask

  // ---------------- driver tasks ----------------
  task automatic preload(input int addr, input logic [31:0] val);
    mem[addr]       = val;
    model_mem[addr] = val;
  endtask

  task automatic run_cmd(input int s, input int d, input int n, input bit fl,
                         input logic [31:0] fv, input int restart_at);
    int budget;
    @(posedge clk); #1;
    model_cmd(s, d, n, fl, fv);
    we_count = 0; last_done_cyc = -1; last_err_cyc = -1; start_cyc = cyc;
    src_addr = 32'(s); dst_addr = 32'(d); len = 16'(n); fill = fl; fill_value = fv;
    start = 1'b1;
    budget = 2 * n + 20;
    for (int k = 1; k < budget && exp_q.size() > 0; k++) begin
      @(posedge clk); #1;
      start = (k == restart_at);
      if (k == restart_at) begin
        src_addr = 32'd7; dst_addr = 32'd8; len = 16'd1; fill = 1'b0;
      end
    end
    start = 1'b0;
    if (exp_q.size() > 0) begin
      checks++; errors++;
      $display("FAIL timeout got=%0d_pending exp=0_pending", exp_q.size());
      exp_q.delete();
    end
  endtask

  // ---------------- directed tests ----------------
  initial begin
    for (int i = 0; i < MEM_WORDS; i++) begin
      mem[i] = '0;
      model_mem[i] = '0;
    end
    preload(100, 32'hA); preload(101, 32'hB); preload(102, 32'hC); preload(103, 32'hD);
    preload(10, 32'd1);  preload(11, 32'd2);  preload(12, 32'd3);
    preload(300, 32'h11); preload(301, 32'h22); preload(302, 32'h33);
    preload(400, 32'h77); preload(401, 32'h55);
    preload(9998, 32'h9A); preload(9999, 32'h9B); preload(10000, 32'h9C);

    #2;
    check("reset_busy", 32'(busy), 0);
    check("reset_done", 32'(done), 0);
    check("reset_we", 32'(mem_WE), 0);
    check("reset_addr", mem_A, 0);
    @(posedge clk); #1;
    rst_n = 1'b1;

    // Plain copy; a start pulse during FINISH must be ignored.
    run_cmd(100, 200, 4, 1'b0, 32'h0, 9);
    check("copy_done_cycle", 32'(last_done_cyc - start_cyc), 9);
    check("copy_we_count", 32'(we_count), 4);
    check("copy_mem200", mem[200], 32'hA);
    check("copy_mem203", mem[203], 32'hD);

    // Zero length.
    run_cmd(5, 6, 0, 1'b0, 32'h0, -1);
    check("len0_done_cycle", 32'(last_done_cyc - start_cyc), 1);
    check("len0_we_count", 32'(we_count), 0);
    check("len0_no_error", 32'(last_err_cyc), 32'hFFFF_FFFF);

    // Source range overrun.
    run_cmd(9999, 0, 3, 1'b0, 32'h0, -1);
    check("srcrange_err_cycle", 32'(last_err_cyc - start_cyc), 1);
    check("srcrange_we_count", 32'(we_count), 0);

    // Destination range overrun.
    run_cmd(0, 9999, 3, 1'b0, 32'h0, -1);
    check("dstrange_err_cycle", 32'(last_err_cyc - start_cyc), 1);

    // Source block ending exactly at the last word is legal.
    run_cmd(9998, 500, 3, 1'b0, 32'h0, -1);
    check("edge_mem502", mem[502], 32'h9C);
    check("edge_done_cycle", 32'(last_done_cyc - start_cyc), 7);

    // Overlapping ascending copy with an ignored start mid-transfer.
    run_cmd(10, 11, 2, 1'b0, 32'h0, 3);
    check("overlap_mem11", mem[11], 32'd1);
    check("overlap_mem12", mem[12], 32'd1);
    check("overlap_done_cycle", 32'(last_done_cyc - start_cyc), 5);
    check("overlap_mem8", mem[8], 32'd0);

    // Reset in cycle 4 of a 4-word copy: only the first word lands.
    @(posedge clk); #1;
    push(0, 0, 0, 0, 0, 0, 1);
    push(1, 0, 0, 0, 100, 0, 0);
    push(1, 0, 0, 1, 400, model_mem[100], 1);
    push(1, 0, 0, 0, 101, 0, 0);
    model_mem[400] = model_mem[100];
    start_cyc = cyc; last_done_cyc = -1;
    src_addr = 32'd100; dst_addr = 32'd400; len = 16'd4; fill = 1'b0; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    rst_n = 1'b0;
    #1;
    check("rst_we_drop", 32'(mem_WE), 0);
    check("rst_busy", 32'(busy), 0);
    check("rst_addr", mem_A, 0);
    if (exp_q.size() > 0) begin
      checks++; errors++;
      $display("FAIL rst_trace got=%0d_pending exp=0_pending", exp_q.size());
      exp_q.delete();
    end
    repeat (2) @(negedge clk);
    @(posedge clk); #1;
    rst_n = 1'b1;
    check("rst_no_done", 32'(last_done_cyc), 32'hFFFF_FFFF);
    check("rst_mem400", mem[400], 32'hA);
    check("rst_mem401", mem[401], 32'h55);
    run_cmd(100, 400, 4, 1'b0, 32'h0, -1);
    check("rst_recopy_mem403", mem[403], 32'hD);

    // Fill request: a fill when compiled in, otherwise an ordinary copy.
    run_cmd(300, 50, 3, 1'b1, 32'hDEADBEEF, -1);
    if (FILL_BUILD) begin
      check("fill_mem50", mem[50], 32'hDEADBEEF);
      check("fill_mem52", mem[52], 32'hDEADBEEF);
      check("fill_done_cycle", 32'(last_done_cyc - start_cyc), 4);
    end else begin
      check("fillcopy_mem50", mem[50], 32'h11);
      check("fillcopy_mem52", mem[52], 32'h33);
      check("fillcopy_done_cycle", 32'(last_done_cyc - start_cyc), 7);
    end

    repeat (2) @(posedge clk);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/dmem_block_mover.md
# dmem_block_mover

Memory-side initiator that drives the single-port data memory (combinational read, write on rising clock edge when write-enable is high) to move word blocks without CPU involvement. It accepts a start command with source, destination and length, then issues alternating read/write accesses on the memory's address/write-data/write-enable port and returns a done pulse. It sits beside the single-cycle core as a second master on the data-memory port; arbitration is outside this block.

## Interface
- ADDR_W, 32, width of word addresses and of mem_A
- DATA_W, 32, data word width
- LEN_W, 16, width of the length field (words)
- MEM_WORDS, 10001, number of addressable words; valid addresses 0..MEM_WORDS-1

- clk  input  1  clock, all state updates on rising edge
- rst_n  input  1  asynchronous, active-low reset
- start  input  1  command strobe, sampled only in IDLE
- src_addr  input  ADDR_W  first source word address
- dst_addr  input  ADDR_W  first destination word address
- len  input  LEN_W  number of words to move
- fill  input  1  fill-mode select (see Configuration)
- fill_value  input  DATA_W  word written in fill mode
- busy  output  1  high while a transfer is in progress
- done  output  1  one-cycle completion pulse
- error  output  1  one-cycle pulse coincident with done when the command was rejected
- mem_A  output  ADDR_W  memory word address
- mem_WD  output  DATA_W  memory write data
- mem_WE  output  1  memory write enable
- mem_RD  input  DATA_W  memory read data (combinational from mem_A)

## Operation
- States: IDLE, READ, WRITE, FINISH.
- IDLE: start=1 latches src_addr, dst_addr, len, fill into internal registers; word index i cleared to 0.
- Range check on latched command, computed at ADDR_W+1 bits: reject if src+len > MEM_WORDS (copy mode) or dst+len > MEM_WORDS. Rejected or len=0 -> FINISH directly, no memory write.
- READ: mem_A = src+i, mem_WE=0; mem_RD captured into data register at end of cycle -> WRITE.
- WRITE: mem_A = dst+i, mem_WD = data register, mem_WE=1; i increments; i == len-1 -> FINISH, else READ.
- FINISH: done=1 (error=1 if rejected), busy=0 -> IDLE.
- Copy is strictly ascending; overlapping ranges with dst > src propagate already-written words. This is the defined behaviour, not an error.
- start outside IDLE (including FINISH) is ignored; latched command is not modified.
- In IDLE/FINISH: mem_WE=0, mem_A=0, mem_WD=0.

## Timing
- Reset (async assert): state IDLE, busy=0, done=0, error=0, mem_WE=0, mem_A=0, mem_WD=0, index and data register 0. mem_WE drops immediately on rst_n falling, so a reset mid-transfer aborts it; words already written stay written, and no done pulse is issued.
- Cycle 0: start sampled in IDLE. Copy of N words: READ in cycles 1,3,…,2N-1; WRITE in cycles 2,4,…,2N; done in cycle 2N+1; a new start is accepted in cycle 2N+2.
- Rejected or len=0: done (with error if rejected) in cycle 1.
- busy is high exactly during READ/WRITE cycles.
- len is unsigned; maximum 2^LEN_W-1 words. The index counter is LEN_W bits and never wraps because termination compares against len-1.

## Configuration
- DMEM_FILL_EN defined: fill=1 at start selects fill mode. READ is skipped and WRITE runs every cycle with mem_WD = latched fill_value. For N words, writes occur in cycles 1..N and done in cycle N+1. The source range is not checked in fill mode.
- DMEM_FILL_EN undefined: fill and fill_value ports remain but are ignored, and every command is a copy. No fill logic is synthesised.

## Test plan
- Copy: preload mem[100..103]=0xA,0xB,0xC,0xD; start src=100, dst=200, len=4 -> writes mem[200..203]=0xA..0xD in cycles 2,4,6,8; done=1 in cycle 9; error=0; busy high in cycles 1..8.
- len=0, start src=5, dst=6 -> done=1 in cycle 1, mem_WE never asserted, error=0.
- Range: start src=9999, dst=0, len=3 -> done=1 and error=1 in cycle 1; no write.
- Overlap/ignored start: mem[10..12]=1,2,3; start src=10, dst=11, len=2; pulse start again in cycle 3 -> mem[11]=1, mem[12]=1; the second start has no effect; done in cycle 5.
- Reset mid-transfer: len=4 copy, deassert rst_n in cycle 4 -> mem_WE=0 immediately; only the first destination word is written; busy=0, no done; a new start after reset completes normally.
- DMEM_FILL_EN: fill=1, fill_value=0xDEADBEEF, dst=50, len=3 -> mem[50..52]=0xDEADBEEF in cycles 1..3; done in cycle 4. With the macro undefined, the same stimulus performs a copy.
